ram8_write_buffer: RTL and testbench

Write-request buffer that sits directly upstream of the RAM8 bank's 8-way load demultiplexer. It queues (address, data) write requests from the CPU-side master with a valid/ready handshake and drains them one at a time as a registered `out_load` / `out_sel` / `out_data` triple. `out_sel` drives the demux select and `out_load` drives its input. Back-to-back writes to the same register are coalesced in the queue.

---
 rtl/ram8_write_buffer_if.sv | 29 ++
 rtl/ram8_write_buffer.sv | 103 ++++++++++
 tb/tb_ram8_write_buffer.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram8_write_buffer_if.sv
// Write-request bus between the CPU-side master and the RAM8 write buffer,
// plus the registered load/select/data triple that feeds the bank demux.
interface ram8_write_buffer_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_valid;
    logic             wr_ready;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             out_load;
    logic [2:0]       out_sel;
    logic [WIDTH-1:0] out_data;
    logic             out_stall;
    logic [CW-1:0]    count;
    logic             idle;

    modport slave (
        input  wr_valid, wr_addr, wr_data, out_stall,
        output wr_ready, out_load, out_sel, out_data, count, idle
    );

    modport master (
        output wr_valid, wr_addr, wr_data, out_stall,
        input  wr_ready, out_load, out_sel, out_data, count, idle
    );
endinterface

// File: rtl/ram8_write_buffer.sv
// Circular write queue with same-address coalescing, draining one registered
// (load, sel, data) triple per cycle into the RAM8 bank demultiplexer.
module ram8_write_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    ram8_write_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [2:0]       addrMem [DEPTH];
    logic [WIDTH-1:0] dataMem [DEPTH];

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    youngest;
    logic [CW-1:0]    count;
    logic [CW-1:0]    countNext;

    logic             outLoad;
    logic [2:0]       outSel;
    logic [WIDTH-1:0] outData;

    logic             ready;
    logic             accept;
    logic             refill;
    logic             pop;
    logic             coalesce;
    logic             push;

    // Handshake decode: ready depends on registered occupancy only
    always_comb begin
        ready    = (count != CW'(DEPTH));
        accept   = bus.wr_valid && ready;
        refill   = !outLoad || !bus.out_stall;
        pop      = refill && (count != '0);
        youngest = tail - PW'(1);
        // A youngest entry leaving on this edge cannot absorb the new write
        coalesce = accept && (count != '0) && (addrMem[youngest] == bus.wr_addr)
                   && !(pop && (count == CW'(1)));
        push     = accept && !coalesce;
    end

    always_comb begin
        countNext = count;
        unique case ({push, pop})
            2'b10:   countNext = count + CW'(1);
            2'b01:   countNext = count - CW'(1);
            default: countNext = count;
        endcase
    end

    // Queue storage holds no reset; occupancy alone defines which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            addrMem[tail] <= bus.wr_addr;
            dataMem[tail] <= bus.wr_data;
        end else if (coalesce) begin
            dataMem[youngest] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= countNext;
        end
    end

    // Output register stage: refilled from the queue head, never from the input bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outLoad <= 1'b0;
            outSel  <= '0;
            outData <= '0;
        end else if (pop) begin
            outLoad <= 1'b1;
            outSel  <= addrMem[head];
            outData <= dataMem[head];
        end else if (refill) begin
            outLoad <= 1'b0;
        end
    end

    assign bus.wr_ready = ready;
    assign bus.out_load = outLoad;
    assign bus.out_sel  = outSel;
    assign bus.out_data = outData;
    assign bus.count    = count;
    assign bus.idle     = (count == '0) && !outLoad;
endmodule

// File: tb/tb_ram8_write_buffer.sv
// Directed bench for ram8_write_buffer: reset, latency, full/stall, coalescing,
// back-to-back streaming and pointer wrap-around against a bank-side log.
module tb_ram8_write_buffer;
    logic clk;
    logic reset;
    int   nVec;
    int   nBad;

    ram8_write_buffer_if #(.DEPTH(4), .WIDTH(16)) bus ();

    ram8_write_buffer #(.DEPTH(4), .WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank-side log of every write the demux actually consumes
    logic [2:0]  seenSel  [$];
    logic [15:0] seenData [$];
    always @(posedge clk) begin
        if (!reset && bus.out_load === 1'b1 && bus.out_stall === 1'b0) begin
            seenSel.push_back(bus.out_sel);
            seenData.push_back(bus.out_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        seenSel.delete();
        seenData.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.out_stall = 1'b0;
        #2 reset = 1'b1;
        #1;
        nVec++;
        if (bus.out_load !== 1'b0 || bus.out_sel !== 3'd0 || bus.out_data !== 16'h0) begin
            nBad++;
            $display("FAIL reset_outputs: got load=%0b sel=%0d data=%h want 0/0/0000",
                     bus.out_load, bus.out_sel, bus.out_data);
        end
        nVec++;
        if (bus.count !== 3'd0 || bus.wr_ready !== 1'b1 || bus.idle !== 1'b1) begin
            nBad++;
            $display("FAIL reset_status: got count=%0d ready=%0b idle=%0b want 0/1/1",
                     bus.count, bus.wr_ready, bus.idle);
        end
        step();
        step();
        reset = 1'b0;
        step();
        clearLog();
    endtask

    task automatic test_latency();
        bus.out_stall = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr = 3'd5;
        bus.wr_data = 16'h1234;
        step();
        bus.wr_valid = 1'b0;
        nVec++;
        if (bus.out_load !== 1'b0 || bus.count !== 3'd1) begin
            nBad++;
            $display("FAIL latency_nobypass: got load=%0b count=%0d want 0/1", bus.out_load, bus.count);
        end
        step();
        nVec++;
        if (bus.out_load !== 1'b1 || bus.out_sel !== 3'd5 || bus.out_data !== 16'h1234) begin
            nBad++;
            $display("FAIL latency_out: got load=%0b sel=%0d data=%h want 1/5/1234",
                     bus.out_load, bus.out_sel, bus.out_data);
        end
        step();
        nVec++;
        if (bus.out_load !== 1'b0 || bus.idle !== 1'b1) begin
            nBad++;
            $display("FAIL latency_drain: got load=%0b idle=%0b want 0/1", bus.out_load, bus.idle);
        end
        clearLog();
    endtask

    task automatic test_full_stall();
        bus.out_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr = 3'(k);
            bus.wr_data = 16'h00A0 + 16'(k);
            step();
        end
        bus.wr_valid = 1'b0;
        nVec++;
        if (bus.count !== 3'd4 || bus.wr_ready !== 1'b0) begin
            nBad++;
            $display("FAIL full_status: got count=%0d ready=%0b want 4/0", bus.count, bus.wr_ready);
        end
        nVec++;
        if (bus.out_load !== 1'b1 || bus.out_sel !== 3'd0 || bus.out_data !== 16'h00A0) begin
            nBad++;
            $display("FAIL full_held: got load=%0b sel=%0d data=%h want 1/0/00a0",
                     bus.out_load, bus.out_sel, bus.out_data);
        end
        bus.out_stall = 1'b0;
        for (int k = 1; k < 5; k++) begin
            step();
            nVec++;
            if (bus.out_load !== 1'b1 || bus.out_sel !== 3'(k) || bus.out_data !== 16'h00A0 + 16'(k)) begin
                nBad++;
                $display("FAIL full_drain%0d: got load=%0b sel=%0d data=%h want 1/%0d/%h",
                         k, bus.out_load, bus.out_sel, bus.out_data, k, 16'h00A0 + 16'(k));
            end
        end
        step();
        nVec++;
        if (bus.idle !== 1'b1) begin
            nBad++;
            $display("FAIL full_idle: got idle=%0b want 1", bus.idle);
        end
        nVec++;
        if (seenSel.size() != 5) begin
            nBad++;
            $display("FAIL full_log_size: got %0d want 5", seenSel.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (seenSel[k] !== 3'(k) || seenData[k] !== 16'h00A0 + 16'(k)) begin
                    nBad++;
                    $display("FAIL full_log%0d: got sel=%0d data=%h want %0d/%h",
                             k, seenSel[k], seenData[k], k, 16'h00A0 + 16'(k));
                    break;
                end
            end
        end
        clearLog();
    endtask

    task automatic test_coalesce();
        // Park a filler write in the output register so the addr-2 pair stays queued
        bus.out_stall = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_addr = 3'd7;
        bus.wr_data = 16'h0077;
        step();
        bus.wr_addr = 3'd2;
        bus.wr_data = 16'h0011;
        step();
        bus.wr_data = 16'h0022;
        step();
        bus.wr_valid = 1'b0;
        nVec++;
        if (bus.count !== 3'd1 || bus.out_sel !== 3'd7) begin
            nBad++;
            $display("FAIL coalesce_count: got count=%0d sel=%0d want 1/7", bus.count, bus.out_sel);
        end
        bus.out_stall = 1'b0;
        step();
        step();
        nVec++;
        if (bus.idle !== 1'b1) begin
            nBad++;
            $display("FAIL coalesce_idle: got idle=%0b want 1", bus.idle);
        end
        nVec++;
        if (seenSel.size() != 2 || seenSel[0] !== 3'd7 || seenSel[1] !== 3'd2 || seenData[1] !== 16'h0022) begin
            nBad++;
            $display("FAIL coalesce_log: got %0d loads (last sel=%0d data=%h) want 2 loads ending 2/0022",
                     seenSel.size(), seenSel.size() > 0 ? seenSel[seenSel.size()-1] : 3'd0,
                     seenData.size() > 0 ? seenData[seenData.size()-1] : 16'h0);
        end
        clearLog();
    endtask

    task automatic test_coalesce_suppressed();
        bus.out_stall = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr = 3'd6;
        bus.wr_data = 16'h0061;
        step();
        bus.wr_data = 16'h0062;
        step();
        bus.wr_valid = 1'b0;
        nVec++;
        if (bus.count !== 3'd1 || bus.out_load !== 1'b1 || bus.out_data !== 16'h0061) begin
            nBad++;
            $display("FAIL suppress_state: got count=%0d load=%0b data=%h want 1/1/0061",
                     bus.count, bus.out_load, bus.out_data);
        end
        step();
        step();
        nVec++;
        if (seenSel.size() != 2 || seenSel[0] !== 3'd6 || seenData[0] !== 16'h0061
            || seenSel[1] !== 3'd6 || seenData[1] !== 16'h0062) begin
            nBad++;
            $display("FAIL suppress_log: got %0d loads want 6/0061 then 6/0062", seenSel.size());
        end
        clearLog();
    endtask

    task automatic test_back_to_back();
        logic [2:0] addrs [4];
        addrs = '{3'd1, 3'd3, 3'd5, 3'd7};
        bus.out_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr = addrs[k];
            bus.wr_data = 16'hC000 + 16'(k);
            step();
            if (k > 0) begin
                nVec++;
                if (bus.out_load !== 1'b1 || bus.out_sel !== addrs[k-1]) begin
                    nBad++;
                    $display("FAIL b2b_%0d: got load=%0b sel=%0d want 1/%0d",
                             k, bus.out_load, bus.out_sel, addrs[k-1]);
                end
            end
        end
        bus.wr_valid = 1'b0;
        step();
        nVec++;
        if (bus.out_load !== 1'b1 || bus.out_sel !== 3'd7 || bus.out_data !== 16'hC003) begin
            nBad++;
            $display("FAIL b2b_last: got load=%0b sel=%0d data=%h want 1/7/c003",
                     bus.out_load, bus.out_sel, bus.out_data);
        end
        step();
        step();
        clearLog();
    endtask

    task automatic test_wrap();
        logic [2:0]  expSel  [$];
        logic [15:0] expData [$];
        int prev;
        int maxCount;
        int bound;
        int a;
        logic accepted;
        logic [15:0] d;
        prev = 8;
        maxCount = 0;
        for (int i = 0; i < 20; i++) begin
            do a = int'($urandom_range(0, 7)); while (a == prev);
            prev = a;
            d = 16'($urandom);
            bus.wr_valid = 1'b1;
            bus.wr_addr = 3'(a);
            bus.wr_data = d;
            accepted = 1'b0;
            bound = 0;
            while (!accepted && bound < 50) begin
                bus.out_stall = 1'($urandom_range(0, 1));
                accepted = bus.wr_ready;
                step();
                if (int'(bus.count) > maxCount) maxCount = int'(bus.count);
                bound++;
            end
            if (!accepted) begin
                nVec++;
                nBad++;
                $display("FAIL wrap_accept%0d: got no accept within 50 cycles want accept", i);
            end
            expSel.push_back(3'(a));
            expData.push_back(d);
        end
        bus.wr_valid = 1'b0;
        bus.out_stall = 1'b0;
        bound = 0;
        while (bus.idle !== 1'b1 && bound < 50) begin
            step();
            bound++;
        end
        nVec++;
        if (bus.idle !== 1'b1) begin
            nBad++;
            $display("FAIL wrap_drain: got idle=%0b want 1", bus.idle);
        end
        nVec++;
        if (maxCount > 4) begin
            nBad++;
            $display("FAIL wrap_maxcount: got %0d want <=4", maxCount);
        end
        nVec++;
        if (seenSel.size() != 20) begin
            nBad++;
            $display("FAIL wrap_log_size: got %0d want 20", seenSel.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                if (seenSel[i] !== expSel[i] || seenData[i] !== expData[i]) begin
                    nBad++;
                    $display("FAIL wrap_log%0d: got sel=%0d data=%h want %0d/%h",
                             i, seenSel[i], seenData[i], expSel[i], expData[i]);
                    break;
                end
            end
        end
        clearLog();
    endtask

    task automatic test_reset_midstream();
        bus.out_stall = 1'b1;
        for (int k = 1; k < 5; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr = 3'(k);
            bus.wr_data = 16'hD000 + 16'(k);
            step();
        end
        bus.wr_valid = 1'b0;
        nVec++;
        if (bus.count !== 3'd3 || bus.out_load !== 1'b1) begin
            nBad++;
            $display("FAIL midreset_pre: got count=%0d load=%0b want 3/1", bus.count, bus.out_load);
        end
        #2 reset = 1'b1;
        #1;
        nVec++;
        if (bus.out_load !== 1'b0 || bus.out_sel !== 3'd0 || bus.count !== 3'd0
            || bus.wr_ready !== 1'b1 || bus.idle !== 1'b1) begin
            nBad++;
            $display("FAIL midreset_async: got load=%0b sel=%0d count=%0d ready=%0b idle=%0b want 0/0/0/1/1",
                     bus.out_load, bus.out_sel, bus.count, bus.wr_ready, bus.idle);
        end
        step();
        step();
        reset = 1'b0;
        bus.out_stall = 1'b0;
        clearLog();
        for (int k = 0; k < 5; k++) step();
        nVec++;
        if (seenSel.size() != 0 || bus.idle !== 1'b1) begin
            nBad++;
            $display("FAIL midreset_after: got %0d loads idle=%0b want 0 loads idle=1",
                     seenSel.size(), bus.idle);
        end
    endtask

    initial begin
        nVec = 0;
        nBad = 0;
        test_reset();
        test_latency();
        test_full_stall();
        test_coalesce();
        test_coalesce_suppressed();
        test_back_to_back();
        test_wrap();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end
endmodule
